// File: rtl/prog_loader.sv
// prog_loader: receives a framed program over an 8-bit valid/ready byte
// stream, packs every three bytes into a 24-bit instruction word and writes
// the words sequentially into instruction memory. The core stays held in
// reset (cpu_run low) until the whole frame has arrived with a good checksum.
//
// Frame: N, then 3*N payload bytes sent MSB byte first, then C.
//   N == 0 means 2^ADDR_W words.
//   C is the mod-256 sum of the payload bytes only (N is not included).
module prog_loader #(
  parameter int ADDR_W = 8,
  parameter int OP_W   = 24   // fixed at three bytes
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              reload,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [OP_W-1:0]   imem_wdata,
  output logic              cpu_run,
  output logic              done,
  output logic              err
);

  localparam logic [2:0] S_HDR  = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_CSUM = 3'd2;
  localparam logic [2:0] S_RUN  = 3'd3;
  localparam logic [2:0] S_ERR  = 3'd4;

  logic [2:0]        state;
  logic [ADDR_W:0]   words_left;  // one bit wider so N == 0 can mean 2^ADDR_W
  logic [1:0]        byte_idx;
  logic [ADDR_W-1:0] word_addr;
  logic [7:0]        acc;
  logic [15:0]       asm_reg;     // first two bytes of the word being built
  logic              xfer;

  // Accept bytes only while a frame is in progress; never while in reset.
  // NOTE: every output of an always_comb is assigned a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    in_ready = 1'b0;
    if (!rst && (state == S_HDR || state == S_LOAD || state == S_CSUM))
      in_ready = 1'b1;
  end

  assign xfer = in_valid && in_ready;

  // Frame FSM, word assembly, checksum accumulation and the registered outputs.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples values from before the edge, whatever the statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_HDR;
      words_left <= '0;
      byte_idx   <= '0;
      word_addr  <= '0;
      acc        <= '0;
      asm_reg    <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cpu_run    <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      case (state)
        S_HDR: begin
          if (xfer) begin
            if (in_data == 8'd0)
              words_left <= {1'b1, {ADDR_W{1'b0}}};
            else
              words_left <= {{(ADDR_W + 1 - 8){1'b0}}, in_data};
            byte_idx  <= '0;
            word_addr <= '0;
            acc       <= '0;
            state     <= S_LOAD;
          end
        end

        S_LOAD: begin
          if (xfer) begin
            acc     <= acc + in_data;
            asm_reg <= {asm_reg[7:0], in_data};
            if (byte_idx == 2'd2) begin
              byte_idx   <= '0;
              imem_we    <= 1'b1;
              imem_addr  <= word_addr;
              imem_wdata <= {asm_reg, in_data};
              word_addr  <= word_addr + 1'b1;
              words_left <= words_left - 1'b1;
              if (words_left == {{ADDR_W{1'b0}}, 1'b1})
                state <= S_CSUM;
            end else begin
              byte_idx <= byte_idx + 2'd1;
            end
          end
        end

        S_CSUM: begin
          if (xfer) begin
            if (in_data == acc) begin
              state   <= S_RUN;
              cpu_run <= 1'b1;
              done    <= 1'b1;
            end else begin
              state <= S_ERR;
              err   <= 1'b1;
            end
          end
        end

        S_RUN: begin
          if (reload) begin
            state   <= S_HDR;
            cpu_run <= 1'b0;
            done    <= 1'b0;
          end
        end

        S_ERR: begin
          // Sticky until rst; reload deliberately ignored.
        end

        default: state <= S_HDR;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed testbench for prog_loader. Inputs change 1 time unit after the
// rising edge; outputs are checked at that same point, and the write monitor
// samples on the falling edge.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        reload;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [23:0] imem_wdata;
  logic        cpu_run;
  logic        done;
  logic        err;

  int n_cmp  = 0;
  int n_fail = 0;

  // Write monitor
  int          wr_cnt = 0;
  int          hits [256];
  logic [23:0] cap_mem [256];
  logic [7:0]  last_addr;

  always #5 clk = ~clk;

  prog_loader #(.ADDR_W(8), .OP_W(24)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .reload     (reload),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_run    (cpu_run),
    .done       (done),
    .err        (err)
  );

  // Record every memory write the loader issues.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      wr_cnt++;
      hits[imem_addr]++;
      cap_mem[imem_addr] = imem_wdata;
      last_addr = imem_addr;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic clear_hits();
    for (int i = 0; i < 256; i++) hits[i] = 0;
    wr_cnt = 0;
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    tick();
    reload = 1'b0;
  endtask

  // Status outputs packed for compact checks: {in_ready, cpu_run, done, err}
  function automatic logic [3:0] status();
    return {in_ready, cpu_run, done, err};
  endfunction

  initial begin
    int bad_addrs;
    int base;

    rst      = 1'b1;
    in_data  = 8'h00;
    in_valid = 1'b0;
    reload   = 1'b0;
    last_addr = 8'h00;
    clear_hits();

    // ---------------- reset state ----------------
    tick();
    tick();
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_status", status(), 4'b0000);
    check("rst_we", imem_we, 1'b0);
    check("rst_addr", imem_addr, 8'h00);
    check("rst_wdata", imem_wdata, 24'h0);
    rst = 1'b0;
    #1;
    check("hdr_in_ready", in_ready, 1'b1);

    // ---------------- good load ----------------
    // Payload sum 12+34+56+AB+CD+EF = 0x303 -> checksum 0x03.
    send(8'h02);
    send(8'h12);
    send(8'h34);
    check("good_no_early_we", imem_we, 1'b0);
    send(8'h56);
    check("good_w0_we", imem_we, 1'b1);
    check("good_w0_addr", imem_addr, 8'h00);
    check("good_w0_data", imem_wdata, 24'h123456);
    send(8'hAB);
    check("good_we_one_cycle", imem_we, 1'b0);
    send(8'hCD);
    send(8'hEF);
    check("good_w1_we", imem_we, 1'b1);
    check("good_w1_addr", imem_addr, 8'h01);
    check("good_w1_data", imem_wdata, 24'hABCDEF);
    check("good_not_run_yet", status(), 4'b1000);
    send(8'h03);
    check("good_run_status", status(), 4'b0110);
    check("good_wr_cnt", wr_cnt, 2);

    // Bytes offered in RUN are not consumed and write nothing.
    in_valid = 1'b1;
    in_data  = 8'h55;
    tick();
    tick();
    in_valid = 1'b0;
    check("run_ignores_stream", wr_cnt, 2);
    check("run_holds", status(), 4'b0110);

    // ---------------- reload ----------------
    // Payload FF FF FF = 0x2FD -> checksum 0xFD.
    pulse_reload();
    check("reload_drop", status(), 4'b1000);
    clear_hits();
    send(8'h01);
    send(8'hFF);
    send(8'hFF);
    send(8'hFF);
    check("reload_w_we", imem_we, 1'b1);
    check("reload_w_addr", imem_addr, 8'h00);
    check("reload_w_data", imem_wdata, 24'hFFFFFF);
    send(8'hFD);
    check("reload_done", status(), 4'b0110);

    // ---------------- bad checksum ----------------
    pulse_reload();
    clear_hits();
    send(8'h02);
    send(8'h12); send(8'h34); send(8'h56);
    send(8'hAB); send(8'hCD); send(8'hEF);
    send(8'h04);
    check("bad_wr_cnt", wr_cnt, 2);
    check("bad_w1_data", cap_mem[1], 24'hABCDEF);
    check("bad_status", status(), 4'b0001);
    pulse_reload();
    tick();
    check("bad_reload_ignored", status(), 4'b0001);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("bad_rst_to_hdr", status(), 4'b1000);

    // ---------------- full depth ----------------
    // 768 bytes of 0x01 sum to 0x300 -> checksum 0x00.
    clear_hits();
    send(8'h00);
    for (int i = 0; i < 768; i++) send(8'h01);
    check("full_not_done_early", status(), 4'b1000);
    send(8'h00);
    check("full_wr_cnt", wr_cnt, 256);
    bad_addrs = 0;
    for (int i = 0; i < 256; i++) if (hits[i] != 1) bad_addrs++;
    check("full_each_addr_once", bad_addrs, 0);
    check("full_last_addr", last_addr, 8'hFF);
    check("full_data0", cap_mem[0], 24'h010101);
    check("full_data255", cap_mem[255], 24'h010101);
    check("full_done", status(), 4'b0110);

    // ---------------- reset mid-frame ----------------
    pulse_reload();
    clear_hits();
    send(8'h01);
    send(8'hAA);
    send(8'hBB);
    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hCC;
    #1;
    check("midrst_in_ready", in_ready, 1'b0);
    tick();
    check("midrst_no_we", imem_we, 1'b0);
    check("midrst_status", status(), 4'b0000);
    check("midrst_addr", imem_addr, 8'h00);
    check("midrst_wdata", imem_wdata, 24'h0);
    in_valid = 1'b0;
    rst = 1'b0;
    tick();
    check("midrst_wr_cnt", wr_cnt, 0);

    // ---------------- gapped stream after reset ----------------
    // Frame 01, 00 00 07, checksum 07, with idle cycles between bytes.
    base = wr_cnt;
    send(8'h01);
    repeat (1 + $urandom_range(0, 2)) tick();
    send(8'h00);
    repeat (1 + $urandom_range(0, 2)) tick();
    send(8'h00);
    repeat (1 + $urandom_range(1, 3)) tick();
    check("gap_no_write_in_gap", wr_cnt, base);
    check("gap_hold_status", status(), 4'b1000);
    send(8'h07);
    check("gap_w_we", imem_we, 1'b1);
    check("gap_w_addr", imem_addr, 8'h00);
    check("gap_w_data", imem_wdata, 24'h000007);
    repeat (1 + $urandom_range(1, 3)) tick();
    check("gap_csum_wait", status(), 4'b1000);
    send(8'h07);
    check("gap_done", status(), 4'b0110);
    check("gap_wr_cnt", wr_cnt, base + 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
